// File: rtl/ahb_apb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_apb_pkg
// Shared definitions for the AHB-Lite to APB bridge: FSM state encoding,
// AHB HTRANS / HRESP encodings and a helper that recognises an active
// (NONSEQ/SEQ) transfer type.
// ----------------------------------------------------------------------------
package ahb_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR1   = 3'd5,
      ST_ERR2   = 3'd6
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // NONSEQ and SEQ both start a real transfer; IDLE and BUSY never do.
   function automatic logic htrans_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_apb_timeout.sv
// ----------------------------------------------------------------------------
// ahb_apb_timeout
// Counts APB ACCESS cycles spent waiting for PREADY.
//   clk, rst_n : bridge clock, asynchronous active-low reset
//   clear      : zero the counter (asserted in the cycle before ACCESS)
//   enable     : count this cycle (ACCESS with PREADY low)
//   expired    : this enabled cycle is the TIMEOUT_CYCLES-th wait cycle
// ----------------------------------------------------------------------------
module ahb_apb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // Flag the cycle whose increment would reach the limit so the FSM can
   // leave ACCESS on exactly the TIMEOUT_CYCLES-th wait cycle.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/ahb_apb_bridge.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge
// AHB-Lite slave to APB master bridge on a single clock. Each accepted AHB
// single transfer becomes one APB SETUP+ACCESS sequence; the AHB data phase
// is stretched with HREADYOUT until PREADY. No PSEL is driven: slave select
// is decoded downstream from PADDR.
//
// Handshake: an AHB transfer is accepted when HSEL & active HTRANS & HREADY
// are sampled high while the bridge is in IDLE or DONE; an APB access
// completes on the clock edge where PENABLE and PREADY are both high.
// PREADY outside ACCESS is ignored.
//
// Ports:
//   PCLK, PRESETn              clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/HWRITE   AHB address phase
//   HWDATA, HREADY             AHB write data, bus ready
//   HREADYOUT/HRDATA/HRESP     AHB response (all registered)
//   PADDR/PWRITE/PWDATA/PENABLE APB request (all registered)
//   PREADY/PRDATA              APB response from decoder
//   dbg_state                  current FSM state
//
// Configuration macro APB_TIMEOUT_EN: abort an ACCESS after TIMEOUT_CYCLES
// wait cycles with a two-cycle AHB ERROR response. Without it the bridge
// waits for PREADY forever and HRESP is constant OKAY.
// ----------------------------------------------------------------------------
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   output logic        PENABLE,
   input  logic        PREADY,
   input  logic [31:0] PRDATA,
   output state_e      dbg_state
);

   state_e state;
   logic   accept;

   assign accept    = HSEL && htrans_active(HTRANS) && HREADY;
   assign dbg_state = state;

`ifdef APB_TIMEOUT_EN
   logic hresp_q;
   logic to_clear;
   logic to_enable;
   logic to_expired;

   // SETUP is always the cycle right before ACCESS, so clearing there means
   // the count starts from zero on entry to ACCESS.
   assign to_clear  = (state == ST_SETUP);
   assign to_enable = (state == ST_ACCESS) && !PREADY;

   ahb_apb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .clear  (to_clear),
      .enable (to_enable),
      .expired(to_expired)
   );

   assign HRESP = hresp_q;
`else
   assign HRESP = HRESP_OKAY;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= ST_IDLE;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PENABLE   <= 1'b0;
         HREADYOUT <= 1'b1;
         HRDATA    <= '0;
`ifdef APB_TIMEOUT_EN
         hresp_q   <= HRESP_OKAY;
`endif
      end else begin
         case (state)
            // DONE shares the accept path with IDLE so back-to-back
            // transfers run without an idle bubble.
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  PADDR     <= HADDR;
                  PWRITE    <= HWRITE;
                  HREADYOUT <= 1'b0;
                  state     <= HWRITE ? ST_WDATA : ST_SETUP;
               end else begin
                  HREADYOUT <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            // Write data is only valid in the AHB data phase, one cycle
            // after the address phase.
            ST_WDATA: begin
               PWDATA <= HWDATA;
               state  <= ST_SETUP;
            end

            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (PREADY) begin
                  PENABLE   <= 1'b0;
                  HREADYOUT <= 1'b1;
                  if (!PWRITE) begin
                     HRDATA <= PRDATA;
                  end
                  state <= ST_DONE;
`ifdef APB_TIMEOUT_EN
               end else if (to_expired) begin
                  PENABLE <= 1'b0;
                  hresp_q <= HRESP_ERROR;
                  state   <= ST_ERR1;
`endif
               end
            end

`ifdef APB_TIMEOUT_EN
            // Two-cycle ERROR: HRESP high with HREADYOUT low, then high.
            ST_ERR1: begin
               HREADYOUT <= 1'b1;
               state     <= ST_ERR2;
            end

            ST_ERR2: begin
               hresp_q <= HRESP_OKAY;
               state   <= ST_IDLE;
            end
`endif

            default: begin
               PENABLE   <= 1'b0;
               HREADYOUT <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ----------------------------------------------------------------------------
// tb_ahb_apb_bridge
// Self-checking bench for ahb_apb_bridge. An AHB master task layer issues
// transfers; an APB slave process answers with per-transfer wait states and
// read data. Expected latency, HRDATA and APB request contents come from a
// transfer-level model (last written data, last read data, last address).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_apb_bridge;
   import ahb_apb_pkg::*;

   localparam int TB_TIMEOUT = 8;

   // ---------------------------------------------------------------- clock/reset
   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic        PENABLE;
   logic        PREADY;
   logic [31:0] PRDATA;
   state_e      dbg_state;
   logic        hready_en;

   always #5 PCLK = ~PCLK;

   // Single-slave interconnect: bus HREADY follows the bridge, with an
   // override used to present HREADY low.
   assign HREADY = HREADYOUT & hready_en;

   ahb_apb_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
      .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA), .dbg_state(dbg_state)
   );

   // ---------------------------------------------------------------- model state
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic [31:0] exp_pwdata;
   } xfer_t;

   xfer_t       pend_q[$];
   xfer_t       slv_q[$];
   logic [31:0] exp_q[$];
   int          n_err = 0;
   int          n_checks = 0;
   int          pen_cycles = 0;
   logic [31:0] last_w = '0;
   logic [31:0] last_rd = '0;
   logic [31:0] last_addr = '0;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   // ---------------------------------------------------------------- APB slave
   initial begin : apb_slave
      xfer_t       cur;
      bit          have;
      int          acc;
      logic        prev_pen, prev_rdy, prev_pw;
      logic [31:0] prev_pa, prev_pd;
      have = 0; acc = 0; prev_pen = 0; prev_rdy = 0; prev_pw = 0;
      prev_pa = '0; prev_pd = '0;
      cur = '{wr: 1'b0, addr: '0, wdata: '0, rdata: '0, waits: 0, exp_pwdata: '0};
      PREADY = 1'b0;
      PRDATA = '0;
      forever begin
         @(negedge PCLK);
         if (!PRESETn) begin
            have = 0; PREADY = 1'b0; prev_pen = 0; prev_rdy = 0;
         end else begin
            if (PENABLE) begin
               pen_cycles++;
               n_checks++;
               if (prev_pen && prev_rdy) begin
                  n_err++;
                  $display("FAIL apb_gap: PENABLE high right after a completed access, got 1 expected 0");
               end
               if (!prev_pen) begin
                  n_checks++;
                  if (PADDR !== prev_pa || PWRITE !== prev_pw || PWDATA !== prev_pd) begin
                     n_err++;
                     $display("FAIL setup_stable: access %h/%0d/%h setup %h/%0d/%h",
                              PADDR, PWRITE, PWDATA, prev_pa, prev_pw, prev_pd);
                  end
                  n_checks++;
                  if (slv_q.size() == 0) begin
                     n_err++;
                     have = 0;
                     $display("FAIL apb_unexpected: access to %h with no transfer pending", PADDR);
                  end else begin
                     cur  = slv_q.pop_front();
                     have = 1;
                     acc  = 0;
                     if ({PWRITE, PADDR, PWDATA} !== {cur.wr, cur.addr, cur.exp_pwdata}) begin
                        n_err++;
                        $display("FAIL apb_request: got wr=%0d addr=%h data=%h expected wr=%0d addr=%h data=%h",
                                 PWRITE, PADDR, PWDATA, cur.wr, cur.addr, cur.exp_pwdata);
                     end
                  end
               end
               if (have && acc == cur.waits) begin
                  PREADY = 1'b1;
                  PRDATA = cur.rdata;
                  have   = 0;
               end else begin
                  PREADY = 1'b0;
                  PRDATA = $urandom;
                  acc++;
               end
            end else begin
               // Noise outside ACCESS: the bridge must ignore it.
               PREADY = 1'($urandom_range(0, 1));
               PRDATA = $urandom;
            end
            prev_pen = PENABLE;
            prev_rdy = PREADY;
         end
         prev_pa = PADDR;
         prev_pw = PWRITE;
         prev_pd = PWDATA;
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic drive_idle();
      HSEL   = 1'($urandom_range(0, 1));
      HTRANS = HTRANS_IDLE;
      HADDR  = $urandom;
      HWRITE = 1'($urandom_range(0, 1));
   endtask

   function automatic xfer_t rand_xfer(input int max_waits);
      xfer_t x;
      x.wr         = 1'($urandom_range(0, 1));
      x.addr       = $urandom & 32'hFFFF_FFFC;
      x.wdata      = $urandom;
      x.rdata      = $urandom;
      x.waits      = $urandom_range(0, max_waits);
      x.exp_pwdata = '0;
      return x;
   endfunction

   // Address phase at the current negedge; records what the APB side and
   // the AHB response must look like for this transfer.
   task automatic issue(input xfer_t x);
      xfer_t s;
      s = x;
      s.exp_pwdata = x.wr ? x.wdata : last_w;
      if (x.wr) last_w = x.wdata;
      slv_q.push_back(s);
      exp_q.push_back(x.wr ? last_rd : x.rdata);
      if (!x.wr) last_rd = x.rdata;
      last_addr = x.addr;
      HSEL   = 1'b1;
      HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      HADDR  = x.addr;
      HWRITE = x.wr;
   endtask

   task automatic wait_done(input xfer_t x, output int lat);
      lat = 0;
      do begin
         @(negedge PCLK);
         lat++;
         if (lat == 1) begin
            drive_idle();
            HWDATA = x.wr ? x.wdata : $urandom;
         end
      end while (!HREADYOUT && lat < x.waits + 12);
   endtask

   task automatic run_pending(input bit pipelined);
      xfer_t       x;
      int          lat;
      int          exp_lat;
      logic [31:0] exp_rd;
      while (pend_q.size() > 0) begin
         x = pend_q.pop_front();
         issue(x);
         wait_done(x, lat);
         exp_lat = (x.wr ? 4 : 3) + x.waits;
         n_checks++;
         if (lat != exp_lat) begin
            n_err++;
            $display("FAIL latency: got %0d cycles expected %0d (wr=%0d waits=%0d)",
                     lat, exp_lat, x.wr, x.waits);
         end
         exp_rd = exp_q.pop_front();
         n_checks++;
         if (HRDATA !== exp_rd) begin
            n_err++;
            $display("FAIL hrdata: got %h expected %h (wr=%0d)", HRDATA, exp_rd, x.wr);
         end
         n_checks++;
         if (HRESP !== HRESP_OKAY) begin
            n_err++;
            $display("FAIL hresp_okay: got %0d expected 0", HRESP);
         end
         if (!pipelined || pend_q.size() == 0) @(negedge PCLK);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      PRESETn = 1'b0;
      repeat (2) @(negedge PCLK);
      n_checks++;
      if ({PADDR, PWRITE, PWDATA, PENABLE} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_apb: got addr=%h wr=%0d data=%h en=%0d expected all 0",
                  PADDR, PWRITE, PWDATA, PENABLE);
      end
      n_checks++;
      if ({HREADYOUT, HRDATA, HRESP} !== {1'b1, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_ahb: got ready=%0d rdata=%h resp=%0d expected 1/0/0",
                  HREADYOUT, HRDATA, HRESP);
      end
      PRESETn = 1'b1;
      @(negedge PCLK);
   endtask

   task automatic test_read_basic();
      int p0;
      p0 = pen_cycles;
      pend_q.push_back('{wr: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, rdata: 32'h1234_5678,
                         waits: 0, exp_pwdata: 32'h0});
      run_pending(1'b0);
      n_checks++;
      if (pen_cycles - p0 != 1) begin
         n_err++;
         $display("FAIL read_penable: got %0d PENABLE cycles expected 1", pen_cycles - p0);
      end
   endtask

   task automatic test_write_waits();
      int p0;
      p0 = pen_cycles;
      pend_q.push_back('{wr: 1'b1, addr: 32'h0000_0004, wdata: 32'hCAFE_F00D, rdata: 32'h0,
                         waits: 3, exp_pwdata: 32'h0});
      run_pending(1'b0);
      n_checks++;
      if (pen_cycles - p0 != 4) begin
         n_err++;
         $display("FAIL write_penable: got %0d PENABLE cycles expected 4", pen_cycles - p0);
      end
      n_checks++;
      if (PWDATA !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL write_pwdata: got %h expected cafef00d", PWDATA);
      end
   endtask

   task automatic test_random_single();
      for (int i = 0; i < 10; i++) pend_q.push_back(rand_xfer(4));
      run_pending(1'b0);
   endtask

   task automatic test_back_to_back();
      xfer_t x;
      x = rand_xfer(0); x.wr = 1'b0; pend_q.push_back(x);
      x = rand_xfer(0); x.wr = 1'b1; pend_q.push_back(x);
      run_pending(1'b1);
      for (int i = 0; i < 12; i++) pend_q.push_back(rand_xfer(3));
      run_pending(1'b1);
   endtask

   task automatic test_ignored();
      int kind;
      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 2);
         HADDR  = $urandom;
         HWRITE = 1'($urandom_range(0, 1));
         case (kind)
            0: begin HSEL = 1'b0; HTRANS = 2'($urandom_range(0, 3)); end
            1: begin HSEL = 1'b1; HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_IDLE : HTRANS_BUSY; end
            default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; hready_en = 1'b0; end
         endcase
         @(negedge PCLK);
         hready_en = 1'b1;
         n_checks++;
         if (PENABLE !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PADDR !== last_addr) begin
            n_err++;
            $display("FAIL ignored: kind=%0d got en=%0d ready=%0d resp=%0d addr=%h expected 0/1/0/%h",
                     kind, PENABLE, HREADYOUT, HRESP, PADDR, last_addr);
         end
      end
      drive_idle();
      @(negedge PCLK);
   endtask

   task automatic test_reset_mid();
      xfer_t x;
      int    seen;
      x = rand_xfer(0);
      x.wr = 1'b1;
      x.waits = 10;
      issue(x);
      seen = 0;
      for (int lat = 1; lat < 20 && seen < 2; lat++) begin
         @(negedge PCLK);
         if (lat == 1) begin
            drive_idle();
            HWDATA = x.wdata;
         end
         if (PENABLE) seen++;
      end
      n_checks++;
      if (seen != 2) begin
         n_err++;
         $display("FAIL reset_mid_reach: got %0d ACCESS cycles expected 2", seen);
      end
      PRESETn = 1'b0;
      #1;
      n_checks++;
      if (PENABLE !== 1'b0 || HREADYOUT !== 1'b1 || PADDR !== 32'h0 || HRESP !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: got en=%0d ready=%0d addr=%h resp=%0d expected 0/1/0/0",
                  PENABLE, HREADYOUT, PADDR, HRESP);
      end
      @(negedge PCLK);
      PRESETn = 1'b1;
      slv_q.delete();
      exp_q.delete();
      last_w = '0;
      last_rd = '0;
      last_addr = '0;
      @(negedge PCLK);
      x = rand_xfer(2); x.wr = 1'b0; pend_q.push_back(x);
      x = rand_xfer(2); x.wr = 1'b1; pend_q.push_back(x);
      run_pending(1'b0);
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      xfer_t       x;
      int          pens;
      logic [31:0] rd_before;
      rd_before = last_rd;
      x = rand_xfer(0);
      x.wr = 1'b0;
      x.waits = 1000;
      issue(x);
      void'(exp_q.pop_back());
      last_rd = rd_before;
      pens = 0;
      for (int lat = 1; lat <= 13; lat++) begin
         @(negedge PCLK);
         if (lat == 1) begin
            drive_idle();
            HWDATA = $urandom;
         end
         if (PENABLE) pens++;
         if (lat == 10) begin
            n_checks++;
            if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || PENABLE !== 1'b0) begin
               n_err++;
               $display("FAIL timeout_err1: got ready=%0d resp=%0d en=%0d expected 0/1/0",
                        HREADYOUT, HRESP, PENABLE);
            end
         end
         if (lat == 11) begin
            n_checks++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || HRDATA !== rd_before) begin
               n_err++;
               $display("FAIL timeout_err2: got ready=%0d resp=%0d rdata=%h expected 1/1/%h",
                        HREADYOUT, HRESP, HRDATA, rd_before);
            end
            // An accept attempt during the error response must be ignored.
            HSEL = 1'b1;
            HTRANS = HTRANS_NONSEQ;
            HADDR = $urandom;
         end
         if (lat == 12) drive_idle();
         if (lat >= 12) begin
            n_checks++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PENABLE !== 1'b0 || PADDR !== x.addr) begin
               n_err++;
               $display("FAIL timeout_idle: got ready=%0d resp=%0d en=%0d addr=%h expected 1/0/0/%h",
                        HREADYOUT, HRESP, PENABLE, PADDR, x.addr);
            end
         end
      end
      n_checks++;
      if (pens != TB_TIMEOUT) begin
         n_err++;
         $display("FAIL timeout_access: got %0d ACCESS cycles expected %0d", pens, TB_TIMEOUT);
      end
      slv_q.delete();
      pend_q.push_back(rand_xfer(2));
      run_pending(1'b0);
   endtask
`else
   task automatic test_long_wait();
      xfer_t x;
      x = rand_xfer(0); x.wr = 1'b0; x.waits = 20; pend_q.push_back(x);
      x = rand_xfer(0); x.wr = 1'b1; x.waits = 15; pend_q.push_back(x);
      run_pending(1'b0);
   endtask
`endif

   // ---------------------------------------------------------------- sequence
   initial begin
      PRESETn   = 1'b0;
      hready_en = 1'b1;
      HWDATA    = '0;
      drive_idle();
      test_reset();
      test_read_basic();
      test_write_waits();
      test_random_single();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
